// File: rtl/fb_pkg.sv
// Shared types, defaults and colour packing helpers for the framebuffer access controller.
package fb_pkg;

    localparam int         FB_FRAME_PIXELS = 307200;
    localparam logic [7:0] FB_PAD          = 8'h00;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RD_REQ = 2'd1,
        WR_REQ = 2'd2,
        SWAP   = 2'd3
    } fb_state_e;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    function automatic logic [31:0] pack_rgb(input rgb_t c);
        return {FB_PAD, c.r, c.g, c.b};
    endfunction

    function automatic rgb_t unpack_rgb(input logic [23:0] w);
        rgb_t c;
        c.r = w[23:16];
        c.g = w[15:8];
        c.b = w[7:0];
        return c;
    endfunction

endpackage

// File: rtl/fb_buf_sel.sv
// Double-buffer bookkeeping: which buffer is drawn into, which one is displayed,
// and whether a frame-complete swap is still waiting for the access FSM to go idle.
module fb_buf_sel
    import fb_pkg::*;
#(
    parameter int FRAME_PIXELS = FB_FRAME_PIXELS,
    parameter int ADDR_W       = 20
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              frame_ready_i,
    input  logic              swap_now_i,
    output logic [ADDR_W-1:0] back_base_o,
    output logic [ADDR_W-1:0] front_base_o,
    output logic              swap_pending_o,
    output logic              swap_done_o
);

    localparam logic [ADDR_W-1:0] BUF1_BASE = ADDR_W'(FRAME_PIXELS);

    logic              back_sel_q,   back_sel_d;
    logic [ADDR_W-1:0] front_base_q, front_base_d;
    logic              swap_pend_q,  swap_pend_d;
    logic              swap_done_q,  swap_done_d;

    assign back_base_o = back_sel_q ? BUF1_BASE : '0;

    always_comb begin
        back_sel_d   = back_sel_q;
        front_base_d = front_base_q;
        swap_done_d  = 1'b0;
        // The swap cycle clears the flag; a frame_ready landing in that same
        // cycle belongs to the frame being swapped and is absorbed.
        swap_pend_d  = swap_now_i ? 1'b0 : (swap_pend_q | frame_ready_i);
        if (swap_now_i) begin
            back_sel_d   = ~back_sel_q;
            front_base_d = back_base_o;
            swap_done_d  = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            back_sel_q   <= 1'b1;
            front_base_q <= '0;
            swap_pend_q  <= 1'b0;
            swap_done_q  <= 1'b0;
        end else begin
            back_sel_q   <= back_sel_d;
            front_base_q <= front_base_d;
            swap_pend_q  <= swap_pend_d;
            swap_done_q  <= swap_done_d;
        end
    end

    assign front_base_o   = front_base_q;
    assign swap_pending_o = swap_pend_q;
    assign swap_done_o    = swap_done_q;

endmodule

// File: rtl/fb_access_ctrl.sv
// Framebuffer access controller: serialises blender read/write strobes onto a
// single-port SRAM req/ack interface and swaps buffers between frames.
module fb_access_ctrl
    import fb_pkg::*;
#(
    parameter int FRAME_PIXELS = FB_FRAME_PIXELS,
    parameter int ADDR_W       = 20,
    parameter int PIX_W        = 19
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [PIX_W-1:0]  pixel_number,
    input  logic              read,
    input  logic              write,
    input  logic [7:0]        write_r,
    input  logic [7:0]        write_g,
    input  logic [7:0]        write_b,
    input  logic              frame_ready,
    output logic [7:0]        read_r,
    output logic [7:0]        read_g,
    output logic [7:0]        read_b,
    output logic              read_valid,
    output logic              busy,
    output logic              err_oob,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack,
    output logic [ADDR_W-1:0] front_base,
    output logic              swap_done
);

    localparam logic [31:0] FRAME_PIXELS_U = FRAME_PIXELS[31:0];

    fb_state_e         state_q, state_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              wr_pend_q, wr_pend_d;
    rgb_t              rgb_q,   rgb_d;
    logic              read_valid_q, read_valid_d;
    logic              err_oob_q,    err_oob_d;

    logic [ADDR_W-1:0] back_base;
    logic              swap_pend;
    logic              swap_now;
    logic              oob;
    logic [ADDR_W-1:0] req_addr;
    rgb_t              wr_rgb;
    logic              rdata_unused;

    assign rdata_unused = ^mem_rdata[31:24];

    fb_buf_sel #(
        .FRAME_PIXELS (FRAME_PIXELS),
        .ADDR_W       (ADDR_W)
    ) u_buf_sel (
        .clk_i          (clk),
        .rst_ni         (reset),
        .frame_ready_i  (frame_ready),
        .swap_now_i     (swap_now),
        .back_base_o    (back_base),
        .front_base_o   (front_base),
        .swap_pending_o (swap_pend),
        .swap_done_o    (swap_done)
    );

    assign oob      = 32'(pixel_number) >= FRAME_PIXELS_U;
    assign req_addr = back_base + ADDR_W'(pixel_number);
    assign wr_rgb   = '{r: write_r, g: write_g, b: write_b};

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wr_pend_d    = wr_pend_q;
        rgb_d        = rgb_q;
        read_valid_d = 1'b0;
        err_oob_d    = 1'b0;
        swap_now     = 1'b0;
        unique case (state_q)
            IDLE: begin
                // A request always wins over a pending swap so the blender's
                // last pixels land in the buffer that is about to be shown.
                if (read || write) begin
                    if (oob) begin
                        err_oob_d = 1'b1;
                    end else begin
                        addr_d = req_addr;
                        if (write) wdata_d = pack_rgb(wr_rgb);
                        if (read) begin
                            wr_pend_d = write;
                            state_d   = RD_REQ;
                        end else begin
                            state_d   = WR_REQ;
                        end
                    end
                end else if (swap_pend && !wr_pend_q) begin
                    state_d = SWAP;
                end
            end
            RD_REQ: begin
                if (mem_ack) begin
                    rgb_d        = unpack_rgb(mem_rdata[23:0]);
                    read_valid_d = 1'b1;
                    state_d      = wr_pend_q ? WR_REQ : IDLE;
                end
            end
            WR_REQ: begin
                if (mem_ack) begin
                    wr_pend_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            SWAP: begin
                swap_now = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            wdata_q      <= '0;
            wr_pend_q    <= 1'b0;
            rgb_q        <= '0;
            read_valid_q <= 1'b0;
            err_oob_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wr_pend_q    <= wr_pend_d;
            rgb_q        <= rgb_d;
            read_valid_q <= read_valid_d;
            err_oob_q    <= err_oob_d;
        end
    end

    // Bus outputs are decoded from the state register, so an asynchronous
    // reset drops the request in the same instant.
    assign mem_req    = (state_q == RD_REQ) || (state_q == WR_REQ);
    assign mem_we     = (state_q == WR_REQ);
    assign mem_addr   = mem_req ? addr_q : '0;
    assign mem_wdata  = mem_we ? wdata_q : '0;
    assign busy       = (state_q != IDLE) || wr_pend_q;
    assign read_r     = rgb_q.r;
    assign read_g     = rgb_q.g;
    assign read_b     = rgb_q.b;
    assign read_valid = read_valid_q;
    assign err_oob    = err_oob_q;

endmodule
